// File: rtl/mem_bus_ctrl_pkg.sv
// mem_bus_ctrl_pkg
//   Shared encodings for the MEM-stage data-bus sequencer: controller state
//   enum, bus-request / stall / write-enable levels, and a helper that sizes
//   the wait-state timer from the timeout value.
package mem_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    MEM_CTRL_IDLE = 2'd0,
    MEM_CTRL_BUSY = 2'd1,
    MEM_CTRL_DONE = 2'd2
  } mem_ctrl_state_e;

  localparam logic BUS_REQ_ENABLE  = 1'b1;
  localparam logic BUS_REQ_DISABLE = 1'b0;
  localparam logic STALL_ENABLE    = 1'b1;
  localparam logic STALL_DISABLE   = 1'b0;
  localparam logic WRITE_ENABLE    = 1'b1;

  // The timer has to hold every value 0..TIMEOUT without wrapping.
  function automatic int timer_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl
//   Sequences one MEM-stage data access at a time onto a req/ack bus with
//   variable wait states. The pipeline is held via stall_req_output until
//   the slave answers; load data is returned on mem_data_output and a
//   missing ack (timeout) or a slave error becomes an error completion.
//
// Bus handshake: bus_req_output is raised with we/addr/sel/wdata on the
//   same edge and all of them stay frozen until the cycle in which the
//   slave drives bus_ack_input or bus_err_input (ack has priority), or the
//   timer expires. bus_rdata_input is only looked at together with ack.
//
// Ports
//   clock, reset                 rising-edge clock, async active-low reset
//   mem_ce/we/addr/sel/data_input   access request from the MEM stage
//   flush_input                  pipeline flush; aborts the completion pulse
//   bus_req/we/addr/sel/wdata_output   bus master outputs
//   bus_ack/err/rdata_input      slave response
//   stall_req_output             hold the pipeline while an access runs
//   mem_data_output              last completed load result
//   mem_done_output              one-cycle completion pulse
//   mem_error_output             qualifies mem_done_output: access failed
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    mem_ce_input,
  input  logic                    mem_we_input,
  input  logic [ADDR_WIDTH-1:0]   mem_addr_input,
  input  logic [DATA_WIDTH/8-1:0] mem_sel_input,
  input  logic [DATA_WIDTH-1:0]   mem_data_input,
  input  logic                    flush_input,
  output logic                    bus_req_output,
  output logic                    bus_we_output,
  output logic [ADDR_WIDTH-1:0]   bus_addr_output,
  output logic [DATA_WIDTH/8-1:0] bus_sel_output,
  output logic [DATA_WIDTH-1:0]   bus_wdata_output,
  input  logic                    bus_ack_input,
  input  logic                    bus_err_input,
  input  logic [DATA_WIDTH-1:0]   bus_rdata_input,
  output logic                    stall_req_output,
  output logic [DATA_WIDTH-1:0]   mem_data_output,
  output logic                    mem_done_output,
  output logic                    mem_error_output
);

  localparam int SEL_WIDTH   = DATA_WIDTH / 8;
  localparam int TIMER_WIDTH = timer_width(TIMEOUT);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT - 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_ONE  = TIMER_WIDTH'(1);

  mem_ctrl_state_e         state_q, state_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [SEL_WIDTH-1:0]    sel_q, sel_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    abort_q, abort_d;
  logic [TIMER_WIDTH-1:0]  timer_q, timer_d;

  logic issue;
  assign issue = mem_ce_input & ~flush_input;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= MEM_CTRL_IDLE;
      req_q   <= BUS_REQ_DISABLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    abort_d = abort_q;
    timer_d = timer_q;

    unique case (state_q)
      MEM_CTRL_IDLE: begin
        if (issue) begin
          req_d   = BUS_REQ_ENABLE;
          we_d    = mem_we_input;
          addr_d  = mem_addr_input;
          sel_d   = mem_sel_input;
          wdata_d = mem_data_input;
          err_d   = 1'b0;
          timer_d = '0;
          state_d = MEM_CTRL_BUSY;
        end
      end

      MEM_CTRL_BUSY: begin
        // Leaving BUSY at timer == TIMEOUT-1 means the timer tops out at
        // TIMEOUT, which the chosen width still represents.
        timer_d = timer_q + TIMER_ONE;
        // A flush cannot cancel a request already on the bus; it only
        // hides the completion from the (now discarded) instruction.
        if (flush_input) begin
          abort_d = 1'b1;
        end
        if (bus_ack_input) begin
          if (we_q != WRITE_ENABLE) begin
            rdata_d = bus_rdata_input;
          end
          err_d   = 1'b0;
          req_d   = BUS_REQ_DISABLE;
          state_d = MEM_CTRL_DONE;
        end else if (bus_err_input || (timer_q == TIMER_LAST)) begin
          err_d   = 1'b1;
          req_d   = BUS_REQ_DISABLE;
          state_d = MEM_CTRL_DONE;
        end
      end

      MEM_CTRL_DONE: begin
        // Single cycle; mem_ce_input is still high for the same
        // instruction here, so never look at it.
        abort_d = 1'b0;
        state_d = MEM_CTRL_IDLE;
      end

      default: begin
        req_d   = BUS_REQ_DISABLE;
        abort_d = 1'b0;
        state_d = MEM_CTRL_IDLE;
      end
    endcase
  end

  assign bus_req_output   = req_q;
  assign bus_we_output    = we_q;
  assign bus_addr_output  = addr_q;
  assign bus_sel_output   = sel_q;
  assign bus_wdata_output = wdata_q;
  assign mem_data_output  = rdata_q;

  assign stall_req_output = ((state_q == MEM_CTRL_IDLE) && issue) ||
                            (state_q == MEM_CTRL_BUSY) ? STALL_ENABLE : STALL_DISABLE;

  assign mem_done_output  = (state_q == MEM_CTRL_DONE) && !abort_q;
  assign mem_error_output = mem_done_output && err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl
//   Bench for mem_bus_ctrl: a bus-slave driver task with programmable wait
//   states / response kind / flush point, a completion scoreboard fed when
//   an access is started and drained on every mem_done_output pulse, and
//   one task per scenario.
module tb_mem_bus_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 15;

  // response kinds for the slave driver
  localparam int RESP_ACK  = 0;
  localparam int RESP_ERR  = 1;
  localparam int RESP_BOTH = 2;
  localparam int RESP_NONE = 3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          mem_ce_input = 1'b0;
  logic          mem_we_input = 1'b0;
  logic [AW-1:0] mem_addr_input = '0;
  logic [SW-1:0] mem_sel_input = '0;
  logic [DW-1:0] mem_data_input = '0;
  logic          flush_input = 1'b0;
  logic          bus_req_output;
  logic          bus_we_output;
  logic [AW-1:0] bus_addr_output;
  logic [SW-1:0] bus_sel_output;
  logic [DW-1:0] bus_wdata_output;
  logic          bus_ack_input = 1'b0;
  logic          bus_err_input = 1'b0;
  logic [DW-1:0] bus_rdata_input = '0;
  logic          stall_req_output;
  logic [DW-1:0] mem_data_output;
  logic          mem_done_output;
  logic          mem_error_output;

  mem_bus_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clock            (clock),
    .reset            (reset),
    .mem_ce_input     (mem_ce_input),
    .mem_we_input     (mem_we_input),
    .mem_addr_input   (mem_addr_input),
    .mem_sel_input    (mem_sel_input),
    .mem_data_input   (mem_data_input),
    .flush_input      (flush_input),
    .bus_req_output   (bus_req_output),
    .bus_we_output    (bus_we_output),
    .bus_addr_output  (bus_addr_output),
    .bus_sel_output   (bus_sel_output),
    .bus_wdata_output (bus_wdata_output),
    .bus_ack_input    (bus_ack_input),
    .bus_err_input    (bus_err_input),
    .bus_rdata_input  (bus_rdata_input),
    .stall_req_output (stall_req_output),
    .mem_data_output  (mem_data_output),
    .mem_done_output  (mem_done_output),
    .mem_error_output (mem_error_output)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard entries: {error, mem_data_output} expected at each done pulse
  logic [DW:0] exp_q[$];
  logic [DW-1:0] model_data = '0;  // last completed load result

  // observations of the last do_access call
  int          r_req;
  int          r_stall;
  int          r_done;
  int          r_cycles;
  logic        r_first_req;
  logic        r_bus_ok;
  logic        r_err;
  logic [DW-1:0] r_data;
  logic        r_timeout;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin : sb_monitor
    logic [DW:0] e;
    #2;
    if (reset && mem_done_output === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_done: got done=1 error=%b data=%h, required no completion",
                 mem_error_output, mem_data_output);
      end else begin
        e = exp_q.pop_front();
        if ({mem_error_output, mem_data_output} !== e) begin
          n_fail++;
          $display("FAIL sb_completion: got error=%b data=%h, required error=%b data=%h",
                   mem_error_output, mem_data_output, e[DW], e[DW-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycle();
    @(negedge clock);
    mem_ce_input  = 1'b0;
    flush_input   = 1'b0;
    bus_ack_input = 1'b0;
    bus_err_input = 1'b0;
    #1;
  endtask

  // Runs one access from the issue cycle through the DONE cycle. The slave
  // answers in BUSY cycle waits+1; the MEM-stage inputs are scrambled while
  // the request is outstanding to prove the bus side stays frozen.
  task automatic do_access(input logic we, input logic [AW-1:0] addr,
                           input logic [SW-1:0] sel, input logic [DW-1:0] wdata,
                           input int waits, input int resp,
                           input logic [DW-1:0] rdata, input int flush_cyc);
    int  busy_idx;
    bit  fin;
    busy_idx = 0;
    fin = 0;
    r_req = 0; r_stall = 0; r_done = 0; r_cycles = 1;
    r_bus_ok = 1'b1; r_err = 1'b0; r_data = '0; r_timeout = 1'b0;
    @(negedge clock);
    mem_ce_input   = 1'b1;
    mem_we_input   = we;
    mem_addr_input = addr;
    mem_sel_input  = sel;
    mem_data_input = wdata;
    flush_input    = 1'b0;
    bus_ack_input  = 1'b0;
    bus_err_input  = 1'b0;
    #1;
    r_first_req = bus_req_output;
    if (bus_req_output)   r_req++;
    if (stall_req_output) r_stall++;
    if (mem_done_output)  r_done++;
    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      @(negedge clock);
      r_cycles++;
      bus_ack_input = 1'b0;
      bus_err_input = 1'b0;
      flush_input   = 1'b0;
      if (bus_req_output) begin
        busy_idx++;
        mem_addr_input = $urandom;
        mem_data_input = $urandom;
        mem_sel_input  = SW'($urandom_range(0, 15));
        mem_we_input   = 1'($urandom_range(0, 1));
        if (resp != RESP_NONE && busy_idx == waits + 1) begin
          bus_ack_input   = (resp == RESP_ACK) || (resp == RESP_BOTH);
          bus_err_input   = (resp == RESP_ERR) || (resp == RESP_BOTH);
          bus_rdata_input = rdata;
        end else begin
          bus_rdata_input = $urandom;
        end
        if (busy_idx == flush_cyc) flush_input = 1'b1;
        #1;
        r_req++;
        if (bus_we_output !== we || bus_addr_output !== addr ||
            bus_sel_output !== sel || bus_wdata_output !== wdata)
          r_bus_ok = 1'b0;
      end else begin
        #1;
        fin = 1;
        r_err  = mem_error_output;
        r_data = mem_data_output;
      end
      if (stall_req_output) r_stall++;
      if (mem_done_output)  r_done++;
    end
    bus_ack_input = 1'b0;
    bus_err_input = 1'b0;
    if (!fin) r_timeout = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #1;
    n_checks++;
    if (bus_req_output !== 1'b0) begin n_fail++;
      $display("FAIL reset_req: got %b, required 0", bus_req_output); end
    n_checks++;
    if ({bus_we_output, bus_addr_output, bus_sel_output, bus_wdata_output} !== '0) begin n_fail++;
      $display("FAIL reset_bus: got we=%b addr=%h sel=%h wdata=%h, required all 0",
               bus_we_output, bus_addr_output, bus_sel_output, bus_wdata_output); end
    n_checks++;
    if (mem_data_output !== '0) begin n_fail++;
      $display("FAIL reset_data: got %h, required 0", mem_data_output); end
    n_checks++;
    if (mem_done_output !== 1'b0 || mem_error_output !== 1'b0) begin n_fail++;
      $display("FAIL reset_done: got done=%b error=%b, required 0 0", mem_done_output, mem_error_output); end
    n_checks++;
    if (stall_req_output !== 1'b0) begin n_fail++;
      $display("FAIL reset_stall: got %b, required 0", stall_req_output); end
    @(negedge clock);
    reset = 1'b1;
    idle_cycle();
  endtask

  task automatic test_load_zero_wait();
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    model_data = 32'hDEADBEEF;
    do_access(1'b0, 32'h100, 4'hF, 32'h0, 0, RESP_ACK, 32'hDEADBEEF, 0);
    n_checks++;
    if (r_timeout || r_req != 1 || r_stall != 2 || r_cycles != 3) begin n_fail++;
      $display("FAIL load0_timing: got req=%0d stall=%0d cycles=%0d to=%b, required 1 2 3 0",
               r_req, r_stall, r_cycles, r_timeout); end
    n_checks++;
    if (!r_bus_ok || r_first_req !== 1'b0) begin n_fail++;
      $display("FAIL load0_bus: got bus_ok=%b first_req=%b, required 1 0", r_bus_ok, r_first_req); end
    n_checks++;
    if (r_done != 1 || r_err !== 1'b0 || r_data !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL load0_result: got done=%0d err=%b data=%h, required 1 0 deadbeef",
               r_done, r_err, r_data); end
    idle_cycle();
  endtask

  task automatic test_store_wait();
    exp_q.push_back({1'b0, model_data});
    do_access(1'b1, 32'h204, 4'h3, 32'h1234, 3, RESP_ACK, 32'hCAFEF00D, 0);
    n_checks++;
    if (r_timeout || r_req != 4 || !r_bus_ok) begin n_fail++;
      $display("FAIL store_busy: got req=%0d bus_ok=%b to=%b, required 4 1 0", r_req, r_bus_ok, r_timeout); end
    n_checks++;
    if (r_done != 1 || r_err !== 1'b0 || r_data !== model_data) begin n_fail++;
      $display("FAIL store_result: got done=%0d err=%b data=%h, required 1 0 %h",
               r_done, r_err, r_data, model_data); end
    idle_cycle();
  endtask

  task automatic test_timeout();
    exp_q.push_back({1'b1, model_data});
    do_access(1'b0, 32'h300, 4'hF, 32'h0, 0, RESP_NONE, 32'h0, 0);
    n_checks++;
    if (r_timeout || r_req != TO || r_stall != TO + 1) begin n_fail++;
      $display("FAIL timeout_len: got req=%0d stall=%0d to=%b, required %0d %0d 0",
               r_req, r_stall, r_timeout, TO, TO + 1); end
    n_checks++;
    if (r_done != 1 || r_err !== 1'b1 || r_data !== model_data) begin n_fail++;
      $display("FAIL timeout_result: got done=%0d err=%b data=%h, required 1 1 %h",
               r_done, r_err, r_data, model_data); end
    idle_cycle();
  endtask

  task automatic test_slave_err();
    exp_q.push_back({1'b1, model_data});
    do_access(1'b0, 32'h400, 4'hF, 32'h0, 1, RESP_ERR, 32'h55AA55AA, 0);
    n_checks++;
    if (r_timeout || r_req != 2 || r_err !== 1'b1 || r_data !== model_data) begin n_fail++;
      $display("FAIL slave_err: got req=%0d err=%b data=%h, required 2 1 %h",
               r_req, r_err, r_data, model_data); end
    idle_cycle();
  endtask

  task automatic test_ack_err_both();
    logic [DW-1:0] d;
    d = $urandom;
    exp_q.push_back({1'b0, d});
    model_data = d;
    do_access(1'b0, 32'h480, 4'hC, 32'h0, 2, RESP_BOTH, d, 0);
    n_checks++;
    if (r_timeout || r_req != 3 || r_err !== 1'b0 || r_data !== d) begin n_fail++;
      $display("FAIL ack_wins: got req=%0d err=%b data=%h, required 3 0 %h", r_req, r_err, r_data, d); end
    idle_cycle();
  endtask

  task automatic test_flush();
    do_access(1'b1, 32'h40, 4'hF, 32'hAA55, 3, RESP_ACK, 32'h0, 2);
    n_checks++;
    if (r_timeout || r_req != 4 || !r_bus_ok) begin n_fail++;
      $display("FAIL flush_hold: got req=%0d bus_ok=%b to=%b, required 4 1 0", r_req, r_bus_ok, r_timeout); end
    n_checks++;
    if (r_done != 0) begin n_fail++;
      $display("FAIL flush_nodone: got %0d done pulses, required 0", r_done); end
    idle_cycle();
    n_checks++;
    if (bus_req_output !== 1'b0 || stall_req_output !== 1'b0) begin n_fail++;
      $display("FAIL flush_reissue: got req=%b stall=%b, required 0 0", bus_req_output, stall_req_output); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d1, d2;
    d1 = $urandom;
    d2 = $urandom;
    exp_q.push_back({1'b0, d1});
    exp_q.push_back({1'b0, d2});
    do_access(1'b0, 32'h10, 4'hF, 32'h0, 0, RESP_ACK, d1, 0);
    n_checks++;
    if (r_timeout || r_done != 1 || r_data !== d1) begin n_fail++;
      $display("FAIL b2b_first: got done=%0d data=%h, required 1 %h", r_done, r_data, d1); end
    do_access(1'b0, 32'h14, 4'hF, 32'h0, 1, RESP_ACK, d2, 0);
    n_checks++;
    if (r_first_req !== 1'b0 || !r_bus_ok || r_req != 2) begin n_fail++;
      $display("FAIL b2b_dup: got first_req=%b bus_ok=%b req=%0d, required 0 1 2",
               r_first_req, r_bus_ok, r_req); end
    n_checks++;
    if (r_timeout || r_cycles != 4 || r_data !== d2) begin n_fail++;
      $display("FAIL b2b_second: got cycles=%0d data=%h, required 4 %h", r_cycles, r_data, d2); end
    model_data = d2;
    idle_cycle();
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] d;
    @(negedge clock);
    mem_ce_input   = 1'b1;
    mem_we_input   = 1'b0;
    mem_addr_input = 32'h500;
    mem_sel_input  = 4'hF;
    @(negedge clock);
    #1;
    n_checks++;
    if (bus_req_output !== 1'b1) begin n_fail++;
      $display("FAIL arst_busy: got req=%b, required 1", bus_req_output); end
    #2;
    reset = 1'b0;
    mem_ce_input = 1'b0;
    #1;
    n_checks++;
    if (bus_req_output !== 1'b0 || stall_req_output !== 1'b0) begin n_fail++;
      $display("FAIL arst_drop: got req=%b stall=%b, required 0 0", bus_req_output, stall_req_output); end
    model_data = '0;
    @(negedge clock);
    reset = 1'b1;
    d = $urandom;
    exp_q.push_back({1'b0, d});
    model_data = d;
    do_access(1'b0, 32'h600, 4'hF, 32'h0, 0, RESP_ACK, d, 0);
    n_checks++;
    if (r_timeout || r_first_req !== 1'b0 || r_req != 1 || r_cycles != 3 || r_data !== d) begin n_fail++;
      $display("FAIL arst_after: got first_req=%b req=%0d cycles=%0d data=%h, required 0 1 3 %h",
               r_first_req, r_req, r_cycles, r_data, d); end
    idle_cycle();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_load_zero_wait();
    test_store_wait();
    test_timeout();
    test_slave_err();
    test_ack_err_both();
    test_flush();
    test_back_to_back();
    test_async_reset();
    idle_cycle();
    idle_cycle();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++;
      $display("FAIL sb_drain: got %0d pending completions, required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200000, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
